// File: rtl/avalon_copy_pkg.sv
// Shared types for the Avalon-MM copy master: FSM state encoding and the RAM word layout.
package avalon_copy_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned DefByteWidth    = 8;
    localparam int unsigned DefBytesPerWord = 4;

    typedef logic [DefBytesPerWord-1:0][DefByteWidth-1:0] word_t;

endpackage

// File: rtl/avalon_copy_master.sv
// Avalon-MM initiator copying a block of words one at a time: read, wait fixed latency, write.
// Optional fill mode (constant pattern, no reads) is enabled by AVALON_COPY_MASTER_FILL_EN.
module avalon_copy_master
    import avalon_copy_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 12,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ADDRESS_WIDTH-1:0]               src_address,
    input  logic [ADDRESS_WIDTH-1:0]               dst_address,
    input  logic [ADDRESS_WIDTH:0]                 length,
    output logic                                   busy,
    output logic                                   done,
    output logic [ADDRESS_WIDTH-1:0]               avm_address,
    output logic [BYTES_PER_WORD-1:0]              avm_byteenable,
    output logic                                   avm_read,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0]   avm_readdata,
    output logic                                   avm_write,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0]   avm_writedata,
`ifdef AVALON_COPY_MASTER_FILL_EN
    input  logic                                   fill_mode,
    input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0]   fill_pattern,
`endif
    input  logic                                   avm_waitrequest
);

    localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [ADDRESS_WIDTH:0] CountOne = 1;

    typedef logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] data_t;

    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] src_q;
    logic [ADDRESS_WIDTH-1:0] dst_q;
    logic [ADDRESS_WIDTH:0]   count_q;
    logic [LatW-1:0]          lat_q;
    data_t                    data_q;
    logic                     fill_q;

    logic  start_fill;
    data_t start_pattern;

`ifdef AVALON_COPY_MASTER_FILL_EN
    assign start_fill    = fill_mode;
    assign start_pattern = fill_pattern;
`else
    assign start_fill    = 1'b0;
    assign start_pattern = '0;
`endif

    assign avm_byteenable = '1;
    assign avm_writedata  = data_q;

    // Outputs are registered alongside the state so each is a clean flop decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_write   <= 1'b0;
            avm_address <= '0;
            data_q      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            count_q     <= '0;
            lat_q       <= '0;
            fill_q      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        src_q   <= src_address;
                        dst_q   <= dst_address;
                        count_q <= length;
                        fill_q  <= start_fill;
                        if (length == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else if (start_fill) begin
                            state       <= StWrite;
                            busy        <= 1'b1;
                            avm_write   <= 1'b1;
                            avm_address <= dst_address;
                            data_q      <= start_pattern;
                        end else begin
                            state       <= StRead;
                            busy        <= 1'b1;
                            avm_read    <= 1'b1;
                            avm_address <= src_address;
                        end
                    end
                end
                StRead: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        lat_q    <= LatW'(READ_LATENCY);
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (lat_q == LatW'(1)) begin
                        data_q      <= avm_readdata;
                        avm_write   <= 1'b1;
                        avm_address <= dst_q;
                        state       <= StWrite;
                    end else begin
                        lat_q <= lat_q - LatW'(1);
                    end
                end
                StWrite: begin
                    if (!avm_waitrequest) begin
                        src_q   <= src_q + 1'b1;
                        dst_q   <= dst_q + 1'b1;
                        count_q <= count_q - CountOne;
                        if (count_q == CountOne) begin
                            avm_write <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= StDone;
                        end else if (fill_q) begin
                            // Fill keeps the write asserted and just steps the address.
                            avm_address <= dst_q + 1'b1;
                        end else begin
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= src_q + 1'b1;
                            state       <= StRead;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_copy_master.sv
// Bench for avalon_copy_master: memory responder, transaction-order model and memory image model.
module tb_avalon_copy_master;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] src_address = '0;
    logic [11:0] dst_address = '0;
    logic [12:0] length = '0;
    logic        busy;
    logic        done;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        fill_mode = 1'b0;
    logic [31:0] fill_pattern = '0;

    int checks = 0;
    int errors = 0;
    bit wait_en = 1'b0;

    logic [31:0] mem   [4096];
    logic [31:0] model [4096];
    txn_t        exp_q [$];

    avalon_copy_master dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .src_address     (src_address),
        .dst_address     (dst_address),
        .length          (length),
        .busy            (busy),
        .done            (done),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
`ifdef AVALON_COPY_MASTER_FILL_EN
        .fill_mode       (fill_mode),
        .fill_pattern    (fill_pattern),
`endif
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Stall pattern changes shortly after each edge so it is stable when the DUT samples it.
    always @(posedge clock) begin
        #2;
        avm_waitrequest = wait_en && ($urandom_range(0, 2) == 0);
    end

    // Fixed latency-1 responder.
    always @(posedge clock) begin
        if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];
        if (avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    end

    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic        prev_wait = 1'b0;
    logic [11:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (avm_read || avm_write)
                check("rd_wr_exclusive", 32'(avm_read & avm_write), 32'h0);
            if ((prev_rd || prev_wr) && prev_wait) begin
                check("hold_req", {30'b0, avm_read, avm_write}, {30'b0, prev_rd, prev_wr});
                check("hold_addr", 32'(avm_address), 32'(prev_addr));
                if (prev_wr) check("hold_data", avm_writedata, prev_data);
            end
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: got wr=%0b addr=%h, expected none",
                             avm_write, avm_address);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    check("txn_kind", 32'(avm_write), 32'(t.wr));
                    check("txn_addr", 32'(avm_address), 32'(t.addr));
                    if (t.wr) check("txn_data", avm_writedata, t.data);
                end
            end
            prev_rd   = avm_read;
            prev_wr   = avm_write;
            prev_wait = avm_waitrequest;
            prev_addr = avm_address;
            prev_data = avm_writedata;
        end
    end

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int j = 0; j < 4096; j++) if (mem[j] !== model[j]) bad++;
        check(name, 32'(bad), 32'h0);
    endtask

    task automatic pulse_start(input logic [11:0] s, input logic [11:0] d, input int len,
                               input bit fill, input logic [31:0] pat);
        @(posedge clock);
        #1;
        start        = 1'b1;
        src_address  = s;
        dst_address  = d;
        length       = 13'(len);
        fill_mode    = fill;
        fill_pattern = pat;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [11:0] s, input logic [11:0] d, input int len, input bit fill,
                       input logic [31:0] pat, input bit stalls, output int busy_cycles);
        int iters = 0;
        int nbusy = 0;
        int nstall = 0;
        int nrw = 0;
        int per;
        bit seen = 1'b0;
        // Ascending word-at-a-time semantics: later reads see earlier writes.
        for (int i = 0; i < len; i++) begin
            logic [11:0] sa;
            logic [11:0] da;
            logic [31:0] w;
            sa = s + 12'(i);
            da = d + 12'(i);
            w  = fill ? pat : model[sa];
            if (!fill) exp_q.push_back('{1'b0, sa, 32'h0});
            exp_q.push_back('{1'b1, da, w});
            model[da] = w;
        end
        wait_en = stalls;
        pulse_start(s, d, len, fill, pat);
        for (int k = 0; k < 20000 && !seen; k++) begin
            @(negedge clock);
            iters++;
            if (busy) nbusy++;
            if ((avm_read || avm_write) && avm_waitrequest) nstall++;
            if ((avm_read || avm_write) && !avm_waitrequest) nrw++;
            if (done) seen = 1'b1;
        end
        wait_en = 1'b0;
        per = fill ? 1 : 3;
        check("done_seen", 32'(seen), 32'h1);
        check("busy_at_done", 32'(busy), 32'h0);
        check("busy_cycles", 32'(nbusy), 32'(per * len + nstall));
        check("done_latency", 32'(iters), 32'(per * len + nstall + 1));
        check("txn_count", 32'(nrw), 32'((fill ? 1 : 2) * len));
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        @(negedge clock);
        check("done_pulse", 32'(done), 32'h0);
        mem_compare("mem_image");
        busy_cycles = nbusy;
    endtask

    initial begin
        int b;
        int wr_seen;
        for (int j = 0; j < 4096; j++) begin
            mem[j]   = 32'h5500_0000 | 32'(j);
            model[j] = mem[j];
        end
        for (int i = 0; i < 4; i++) begin
            mem[16 + i]   = 32'hA0A0_A0A0 + 32'(i);
            model[16 + i] = mem[16 + i];
        end

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_read", 32'(avm_read), 32'h0);
        check("rst_write", 32'(avm_write), 32'h0);
        check("rst_addr", 32'(avm_address), 32'h0);
        check("rst_wdata", avm_writedata, 32'h0);
        check("rst_byteenable", 32'(avm_byteenable), 32'hF);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic copy.
        run(12'h010, 12'h100, 4, 1'b0, 32'h0, 1'b0, b);
        check("t1_busy_12", 32'(b), 32'd12);
        check("t1_dst0", mem[12'h100], 32'hA0A0_A0A0);
        check("t1_dst3", mem[12'h103], 32'hA0A0_A0A3);
        check("t1_src3_kept", mem[12'h013], 32'hA0A0_A0A3);

        // Zero length.
        run(12'h050, 12'h060, 0, 1'b0, 32'h0, 1'b0, b);
        check("t2_busy_0", 32'(b), 32'd0);

        // Address wrap.
        run(12'hFFE, 12'h7FE, 4, 1'b0, 32'h0, 1'b0, b);
        check("t3_dst7fe", mem[12'h7FE], 32'h5500_0FFE);
        check("t3_dst800", mem[12'h800], 32'h5500_0000);
        check("t3_dst801", mem[12'h801], 32'h5500_0001);

        // Overlapping forward copy replicates the first word.
        run(12'h200, 12'h201, 3, 1'b0, 32'h0, 1'b0, b);
        check("t4_dst203", mem[12'h203], 32'h5500_0200);

        // Random stalls on reads and writes.
        run(12'h600, 12'h700, 6, 1'b0, 32'h0, 1'b1, b);
        check("t5_dst705", mem[12'h705], 32'h5500_0605);

        // Reset after the second of eight words.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{1'b0, 12'h300 + 12'(i), 32'h0});
            exp_q.push_back('{1'b1, 12'h400 + 12'(i), model[12'h300 + 12'(i)]});
            model[12'h400 + 12'(i)] = model[12'h300 + 12'(i)];
        end
        pulse_start(12'h300, 12'h400, 8, 1'b0, 32'h0);
        wr_seen = 0;
        for (int k = 0; k < 200 && wr_seen < 2; k++) begin
            @(negedge clock);
            if (avm_write && !avm_waitrequest) wr_seen++;
        end
        check("t6_two_writes", 32'(wr_seen), 32'd2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_reqs", {30'b0, avm_read, avm_write}, 32'h0);
        check("t6_queue", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        mem_compare("t6_mem_image");
        check("t6_dst401", mem[12'h401], 32'h5500_0301);
        check("t6_dst402_kept", mem[12'h402], 32'h5500_0402);
        run(12'h300, 12'h500, 3, 1'b0, 32'h0, 1'b0, b);
        check("t6_restart_dst502", mem[12'h502], 32'h5500_0302);

`ifdef AVALON_COPY_MASTER_FILL_EN
        run(12'h000, 12'h020, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, b);
        check("t7_busy_3", 32'(b), 32'd3);
        check("t7_dst22", mem[12'h022], 32'hDEAD_BEEF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
